// File: rtl/div_share_pkg.sv
// Shared types and constants for the divider-sharing arbiter.
// Saturation constants are the quotients reported for division by zero when DIV_ZERO_CHECK_EN is set.
package div_share_pkg;

  localparam int DIV_WIDTH = 128;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] Q_MAX = {1'b0, {(DIV_WIDTH-1){1'b1}}};
  localparam logic [DIV_WIDTH-1:0] Q_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage

// File: rtl/div_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
// The pointer itself is owned by the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx
);

  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;

  // cand_idx[k] is the requester k places after the pointer.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign cand_idx[gi] = IDX_W'((int'(rr_ptr) + gi) % NUM_REQ);
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    winner_idx = '0;
    winner_oh  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        winner_idx = cand_idx[k];
      end
    end
    if (|req) begin
      winner_oh = NUM_REQ'(1) << winner_idx;
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one fixed-latency signed divider between NUM_REQ requesters, round-robin.
// Optional macro DIV_ZERO_CHECK_EN: bypass and saturate on a zero divisor, adds div_zero_err.
module div_share_arbiter
  import div_share_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = DIV_WIDTH,
  parameter int DIV_LATENCY = 202,
  parameter int CNT_W       = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] x_in,
  input  logic [NUM_REQ*WIDTH-1:0] y_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         q_out,
  output logic                     busy,
  output logic [WIDTH-1:0]         div_x,
  output logic [WIDTH-1:0]         div_y,
  output logic                     div_start,
  input  logic [WIDTH-1:0]         div_q
`ifdef DIV_ZERO_CHECK_EN
  ,
  output logic                     div_zero_err
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_LATENCY - 1);
`ifdef DIV_ZERO_CHECK_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  div_state_t         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   tag_reg;
  logic               bypass_reg;
  logic [WIDTH-1:0]   bypass_q_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [NUM_REQ-1:0] done_reg;
  logic [WIDTH-1:0]   q_out_reg;
  logic               busy_reg;
  logic [WIDTH-1:0]   div_x_reg;
  logic [WIDTH-1:0]   div_y_reg;
  logic               div_start_reg;
`ifdef DIV_ZERO_CHECK_EN
  logic               zero_err_pend_reg;
  logic               div_zero_err_reg;
`endif

  logic [WIDTH-1:0]   x_arr [NUM_REQ];
  logic [WIDTH-1:0]   y_arr [NUM_REQ];
  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   ptr_next;
  logic [WIDTH-1:0]   win_x;
  logic [WIDTH-1:0]   win_y;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign x_arr[gi] = x_in[gi*WIDTH +: WIDTH];
      assign y_arr[gi] = y_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (req),
    .rr_ptr     (rr_ptr_reg),
    .winner_oh  (win_oh),
    .winner_idx (win_idx)
  );

  assign win_x    = x_arr[win_idx];
  assign win_y    = y_arr[win_idx];
  assign ptr_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rr_ptr_reg    <= '0;
      tag_reg       <= '0;
      bypass_reg    <= 1'b0;
      bypass_q_reg  <= '0;
      gnt_reg       <= '0;
      done_reg      <= '0;
      q_out_reg     <= '0;
      busy_reg      <= 1'b0;
      div_x_reg     <= '0;
      div_y_reg     <= '0;
      div_start_reg <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      zero_err_pend_reg <= 1'b0;
      div_zero_err_reg  <= 1'b0;
`endif
    end else begin
      gnt_reg       <= '0;
      done_reg      <= '0;
      div_start_reg <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      div_zero_err_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (cnt_reg != LAST_CNT) begin
            // After reset the divider may still be busy with an aborted job.
            cnt_reg  <= cnt_reg + 1'b1;
            busy_reg <= 1'b0;
          end else if (|req) begin
            gnt_reg    <= win_oh;
            div_x_reg  <= win_x;
            div_y_reg  <= win_y;
            tag_reg    <= win_idx;
            rr_ptr_reg <= ptr_next;
            busy_reg   <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
            zero_err_pend_reg <= 1'b0;
`endif
            if (win_x == '0) begin
              bypass_reg   <= 1'b1;
              bypass_q_reg <= '0;
              state_reg    <= CAPTURE;
            end
`ifdef DIV_ZERO_CHECK_EN
            else if (win_y == '0) begin
              bypass_reg        <= 1'b1;
              bypass_q_reg      <= win_x[WIDTH-1] ? SAT_NEG : SAT_POS;
              zero_err_pend_reg <= 1'b1;
              state_reg         <= CAPTURE;
            end
`endif
            else begin
              bypass_reg <= 1'b0;
              state_reg  <= ISSUE;
            end
          end else begin
            busy_reg <= 1'b0;
          end
        end
        ISSUE: begin
          div_start_reg <= 1'b1;
          cnt_reg       <= '0;
          state_reg     <= WAIT;
        end
        WAIT: begin
          if (cnt_reg == LAST_CNT) begin
            state_reg <= CAPTURE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        CAPTURE: begin
          // Leaving the counter at LAST_CNT lets IDLE grant again straight away.
          q_out_reg <= bypass_reg ? bypass_q_reg : div_q;
          done_reg  <= NUM_REQ'(1) << tag_reg;
          cnt_reg   <= LAST_CNT;
          state_reg <= IDLE;
`ifdef DIV_ZERO_CHECK_EN
          div_zero_err_reg <= zero_err_pend_reg;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign done      = done_reg;
  assign q_out     = q_out_reg;
  assign busy      = busy_reg;
  assign div_x     = div_x_reg;
  assign div_y     = div_y_reg;
  assign div_start = div_start_reg;
`ifdef DIV_ZERO_CHECK_EN
  assign div_zero_err = div_zero_err_reg;
`endif

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a Q64.64 fixed-latency divider model.
// DIV_ZERO_CHECK_EN adds the divide-by-zero bypass cases.
module tb_div_share_arbiter;
  import div_share_pkg::*;

  localparam int N = 4;
  localparam int W = 128;
  localparam int L = 202;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] x_in = '0;
  logic [N*W-1:0] y_in = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   q_out;
  logic           busy;
  logic [W-1:0]   div_x;
  logic [W-1:0]   div_y;
  logic           div_start;
  logic [W-1:0]   div_q = '0;
`ifdef DIV_ZERO_CHECK_EN
  logic           div_zero_err;
`endif

  int cyc = 0;
  int n_start = 0;
  int n_done = 0;
  int n_gnt = 0;
  int last_start = 0;
  int n_checks = 0;
  int n_pass = 0;
  int mcnt = 0;
  logic [W-1:0] mres = '0;

  div_share_arbiter #(
    .NUM_REQ     (N),
    .WIDTH       (W),
    .DIV_LATENCY (L),
    .CNT_W       (9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .x_in      (x_in),
    .y_in      (y_in),
    .gnt       (gnt),
    .done      (done),
    .q_out     (q_out),
    .busy      (busy),
    .div_x     (div_x),
    .div_y     (div_y),
    .div_start (div_start),
    .div_q     (div_q)
`ifdef DIV_ZERO_CHECK_EN
    ,
    .div_zero_err (div_zero_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Q64.64 divider: quotient becomes valid L cycles after the start cycle.
  function automatic logic [W-1:0] fxdiv(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] n, d, r;
    n = $signed({{W{x[W-1]}}, x}) <<< 64;
    d = $signed({{W{y[W-1]}}, y});
    if (d == 0) return '1;
    r = n / d;
    return r[W-1:0];
  endfunction

  always @(posedge clk) begin
    if (div_start) begin
      mcnt  <= 1;
      mres  <= fxdiv(div_x, div_y);
      div_q <= {64{2'b10}};
    end else if (mcnt != 0) begin
      mcnt <= mcnt + 1;
      if (mcnt == L - 1) begin
        div_q <= mres;
        mcnt  <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (div_start) begin
      n_start++;
      last_start = cyc;
    end
    if (done != '0) n_done++;
    if (gnt != '0) n_gnt++;
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_gnt(output int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == '0 && n < 1000);
    t = cyc;
  endtask

  task automatic wait_done(output int t);
    int n = 0;
    while (done == '0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
  endtask

  task automatic check_idle_outputs();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_q_out", q_out, 0);
    check("rst_busy", busy, 0);
    check("rst_div_x", div_x, 0);
    check("rst_div_y", div_y, 0);
    check("rst_div_start", div_start, 0);
  endtask

  task automatic serve_one(input int idx, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] exp_q, input int exp_lat, input bit perturb);
    int t_g, t_d, s0;
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    s0 = n_start;
    x_in[idx*W +: W] = x;
    y_in[idx*W +: W] = y;
    req[idx] = 1'b1;
    wait_gnt(t_g);
    check("gnt", gnt, oh);
    check("busy_at_gnt", busy, 1);
    check("div_x_latch", div_x, x);
    check("div_y_latch", div_y, y);
    req[idx] = 1'b0;
    if (perturb) begin
      x_in[idx*W +: W] = ~x;
      y_in[idx*W +: W] = ~y;
    end
    @(negedge clk);
    check("gnt_pulse", gnt, 0);
    check("div_start_t1", div_start, (exp_lat > 1) ? 1 : 0);
    if (perturb) begin
      repeat (99) @(negedge clk);
      check("div_x_hold", div_x, x);
      check("div_y_hold", div_y, y);
    end
    wait_done(t_d);
    check("done", done, oh);
    check("q_out", q_out, exp_q);
    check("latency", t_d - t_g, exp_lat);
    check("busy_at_done", busy, 1);
    check("start_count", n_start - s0, (exp_lat > 1) ? 1 : 0);
`ifdef DIV_ZERO_CHECK_EN
    check("div_zero_err", div_zero_err, (y == '0 && x != '0) ? 1 : 0);
`endif
    $display("txn req%0d gnt@%0d done@%0d lat=%0d q=%h", idx, t_g, t_d, t_d - t_g, q_out);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("q_hold", q_out, exp_q);
    check("busy_low", busy, 0);
`ifdef DIV_ZERO_CHECK_EN
    check("div_zero_err_pulse", div_zero_err, 0);
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rel, t_g, t_d, d0, g0, exp_id;

    // Power-on reset.
    repeat (3) @(negedge clk);
    check_idle_outputs();
    rst = 1'b0;
    rel = cyc;

    // Single request, also covers the post-reset guard.
    serve_one(0, W'(100) << 64, W'(4) << 64, W'(25) << 64, L + 2, 1'b0);
    check("por_guard", (last_start - rel) >= L, 1);

    // Reset while the counter is at 50.
    x_in[1*W +: W] = W'(100) << 64;
    y_in[1*W +: W] = W'(4) << 64;
    req[1] = 1'b1;
    wait_gnt(t_g);
    check("abort_gnt", gnt, 4'b0010);
    req[1] = 1'b0;
    repeat (51) @(negedge clk);
    check("abort_busy", busy, 1);
    d0 = n_done;
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs();
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;

    // Contention: all four held, pointer back at 0 after reset.
    for (int i = 0; i < N; i++) begin
      x_in[i*W +: W] = W'(12 * (i + 1)) << 64;
      y_in[i*W +: W] = W'(3) << 64;
    end
    req = '1;
    g0 = n_gnt;
    for (int k = 0; k < 5; k++) begin
      exp_id = k % N;
      wait_gnt(t_g);
      check("rr_gnt", gnt, N'(1) << exp_id);
      if (k == 0) check("abort_no_done", n_done - d0, 0);
      if (k == 4) req = '0;
      wait_done(t_d);
      check("rr_done", done, N'(1) << exp_id);
      check("rr_q_out", q_out, W'(4 * (exp_id + 1)) << 64);
      check("rr_latency", t_d - t_g, L + 2);
      check("rr_gnt_count", n_gnt - g0, k + 1);
      if (k == 0) check("abort_guard", (last_start - rel) >= L, 1);
      $display("txn req%0d gnt@%0d done@%0d lat=%0d q=%h", exp_id, t_g, t_d, t_d - t_g, q_out);
    end

    // Zero dividend bypasses the divider.
    serve_one(2, '0, W'(7), '0, 1, 1'b0);

    // Negative dividend, operands perturbed during WAIT.
    serve_one(3, -(W'(9) << 64), W'(3) << 64, -(W'(3) << 64), L + 2, 1'b1);

`ifdef DIV_ZERO_CHECK_EN
    serve_one(0, -W'(5), '0, Q_MIN, 1, 1'b0);
    serve_one(1, W'(5), '0, Q_MAX, 1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares one signed 128-bit sequential divider (X/Y → Q, Start-pulsed, fixed latency, no done output) between NUM_REQ requesters.
- Round-robin arbitration; latches the winner's operands, pulses the divider start, counts the fixed latency, then returns the quotient with a per-requester done pulse.
- Sits between the filter-update engines and the single divider instance in the H-infinity datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 128, operand/quotient width, signed two's complement.
- DIV_LATENCY, 202, cycles from the div_start-high cycle until div_q is stable; must be ≥4.
- CNT_W, 9, latency counter width; must satisfy 2^CNT_W > DIV_LATENCY.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held until gnt.
- x_in  in  NUM_REQ*WIDTH  dividends; slice i = [i*WIDTH +: WIDTH].
- y_in  in  NUM_REQ*WIDTH  divisors, same slicing.
- gnt  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- done  out  NUM_REQ  one-hot, one-cycle result-valid pulse.
- q_out  out  WIDTH  quotient, valid in the done cycle and held until the next done.
- busy  out  1  high from gnt until done, inclusive.
- div_x  out  WIDTH  latched dividend to the divider.
- div_y  out  WIDTH  latched divisor to the divider.
- div_start  out  1  one-cycle start pulse to the divider.
- div_q  in  WIDTH  divider quotient.

Behaviour:
- Reset values: gnt=0, done=0, q_out=0, busy=0, div_x=0, div_y=0, div_start=0, rr_ptr=0, state=IDLE, counter=0.
- States: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE: if any req bit is set, pick the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - Same cycle: gnt[winner]=1, latch x/y of the winner into div_x/div_y, latch the tag.
  - rr_ptr ← winner+1 (wraps to 0 after NUM_REQ-1).
  - Next state ISSUE; busy=1 from the gnt cycle.
- Zero-dividend bypass: if the winning dividend == 0, skip the divider and go IDLE→CAPTURE with result 0.
  - done fires 1 cycle after gnt.
- ISSUE: div_start=1 for exactly this cycle; counter←0; go to WAIT.
- WAIT: counter increments each cycle. When counter == DIV_LATENCY-1, go to CAPTURE.
- CAPTURE: q_out ← div_q (or 0 on bypass); done[tag]=1; busy=0 next cycle; go to IDLE.
  - A new grant may occur in the cycle after CAPTURE at the earliest.
- Latency (normal path): done fires DIV_LATENCY+2 cycles after gnt.
- Requests arriving while busy are ignored; the requester keeps req high.
- A req that drops before gnt is simply not served; dropping req after gnt has no effect.
- Simultaneous requests: strict round-robin; no requester waits more than NUM_REQ-1 services.
- div_x/div_y are held constant from gnt until CAPTURE.
- rst mid-operation: abort immediately, all outputs to reset values, no done for the in-flight request.
  - The divider is not reset by this block; the next div_start is issued no earlier than DIV_LATENCY cycles after the abort.
  - Enforce this with a post-reset guard count in IDLE, reusing the counter.
- Arithmetic: no arithmetic on operands except the ==0 comparisons; all values pass through as signed WIDTH bits.

Optional Feature:
- Macro: DIV_ZERO_CHECK_EN.
- When defined, a winning divisor == 0 (with nonzero dividend) bypasses the divider (IDLE→CAPTURE, done 1 cycle after gnt).
  - q_out = {1'b0,{WIDTH-1{1'b1}}} when the dividend is positive.
  - q_out = {1'b1,{WIDTH-1{1'b0}}} when the dividend is negative.
  - Adds output port div_zero_err (1 bit), high in the done cycle only.
- When undefined: the divisor is passed to the divider unchecked, the result is whatever the divider produces, and the div_zero_err port is absent.

Decomposition:
- Package div_share_pkg holds the state enum (IDLE, ISSUE, WAIT, CAPTURE), the WIDTH default, and the saturation constants Q_MAX/Q_MIN.
- One sub-module, rr_arbiter: NUM_REQ-wide round-robin picker.
  - Inputs: req, rr_ptr. Outputs: one-hot winner, winner index.
  - Purely combinational; rr_ptr stays in the parent.

Test Plan:
- Single request: req[0]=1, x=100<<64, y=4<<64, with a divider model at DIV_LATENCY=202 → gnt[0] at cycle t, div_start at t+1, done[0] at t+204, q_out=25<<64.
- Contention: req=4'b1111 held; rr_ptr=0 → grant order 0,1,2,3,0 with no starvation. Each done precedes the next gnt; busy is never low between done and the next gnt except the one IDLE cycle.
- Zero dividend: req[2]=1, x=0, y=7 → done[2] one cycle after gnt, q_out=0, div_start never asserted.
- Reset mid-WAIT: rst at counter=50 → all outputs 0, no done. The next gnt is accepted but div_start is not issued until ≥202 cycles after reset.
- Negative operands: x=-(9<<64), y=3<<64 → q_out=-(3<<64) on done. div_x/div_y are stable throughout WAIT even if x_in changes.
- DIV_ZERO_CHECK_EN: x=-5, y=0 → q_out=128'h8000…0, div_zero_err=1 for one cycle. x=5, y=0 → q_out=128'h7FFF…F.
